// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage request and HI/LO result bundle for the multiply/divide sequencer
interface muldiv_seq_if #(parameter int DATA_W = 32);
    logic [7:0]        alucontrol_i;
    logic              valid_i;
    logic              flush_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              stall_o;
    logic              busy_o;
    logic              hilo_we_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              dbz_o;
    modport master (
        output alucontrol_i, valid_i, flush_i, a_i, b_i,
        input  stall_o, busy_o, hilo_we_o, hi_o, lo_o, dbz_o
    );
    modport slave (
        input  alucontrol_i, valid_i, flush_i, a_i, b_i,
        output stall_o, busy_o, hilo_we_o, hi_o, lo_o, dbz_o
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 shift-add multiply / restoring divide sequencer driving a one-cycle HI/LO write
module muldiv_seq #(parameter int DATA_W = 32) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo;
    logic                r_div, r_neg_q, r_neg_r, r_dbz;
    logic                w_start, w_signed, w_div;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b, w_q, w_r, w_hi, w_lo;
    logic [DATA_W:0]     w_sum, w_diff;
    logic [2*DATA_W:0]   w_sh;
    logic [2*DATA_W-1:0] w_iter, w_prod;
    always_comb begin
        w_signed = bus.alucontrol_i == EXE_MULT_OP || bus.alucontrol_i == EXE_DIV_OP;
        w_div    = bus.alucontrol_i == EXE_DIV_OP || bus.alucontrol_i == EXE_DIVU_OP;
        w_start  = bus.valid_i & ~bus.flush_i & (w_signed | w_div | bus.alucontrol_i == EXE_MULTU_OP);
        w_mag_a  = (w_signed & bus.a_i[DATA_W-1]) ? -bus.a_i : bus.a_i;
        w_mag_b  = (w_signed & bus.b_i[DATA_W-1]) ? -bus.b_i : bus.b_i;
        // multiply: add multiplicand into the upper half, then shift the whole accumulator right
        w_sum    = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_acc[0] ? r_b : {DATA_W{1'b0}}};
        // divide: shift left, trial-subtract the divisor from the partial remainder
        w_sh     = {r_acc, 1'b0};
        w_diff   = w_sh[2*DATA_W:DATA_W] - {1'b0, r_b};
        w_iter   = !r_div ? {w_sum, r_acc[DATA_W-1:1]} :
                   !w_diff[DATA_W] ? {w_diff[DATA_W-1:0], w_sh[DATA_W-1:1], 1'b1} : w_sh[2*DATA_W-1:0];
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_q      = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
        w_r      = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
        w_hi     = r_dbz ? r_a : r_div ? w_r : w_prod[2*DATA_W-1:DATA_W];
        w_lo     = r_dbz ? {DATA_W{1'b1}} : r_div ? w_q : w_prod[DATA_W-1:0];
    end
    always_comb begin
        w_next        = r_state == IDLE ? (w_start ? CALC : IDLE) :
                        r_state == CALC ? (bus.flush_i ? IDLE : r_cnt == LAST ? DONE : CALC) : IDLE;
        bus.stall_o   = r_state == IDLE ? w_start : r_state == CALC;
        bus.busy_o    = r_state != IDLE;
        bus.hilo_we_o = r_state == DONE && !bus.flush_i;
        bus.dbz_o     = r_state == DONE && r_dbz;
        bus.hi_o      = r_state == DONE ? w_hi : r_hi;
        bus.lo_o      = r_state == DONE ? w_lo : r_lo;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (r_state == IDLE && w_start) begin
            r_cnt   <= '0;
            r_acc   <= {{DATA_W{1'b0}}, w_mag_a};
            r_a     <= bus.a_i;
            r_b     <= w_mag_b;
            r_div   <= w_div;
            r_neg_q <= w_signed & (bus.a_i[DATA_W-1] ^ bus.b_i[DATA_W-1]);
            r_neg_r <= w_signed & bus.a_i[DATA_W-1];
            r_dbz   <= w_div & (bus.b_i == '0);
        end else if (r_state == CALC) begin
            r_acc   <= w_iter;
            r_cnt   <= r_cnt + 1'b1;
        end else if (r_state == DONE) begin
            r_hi    <= w_hi;
            r_lo    <= w_lo;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1a;
    localparam logic [7:0] OP_DIVU  = 8'h1b;
    logic clk, rst;
    int checks = 0, errors = 0;
    logic [31:0] last_hi = '0, last_lo = '0;
    muldiv_seq_if #(.DATA_W(32)) mif ();
    muldiv_seq #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(mif.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end
    function automatic logic [64:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULT) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (op == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == 0) return {1'b1, a, 32'hffff_ffff};
        if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic watch(input int n, output int strobes);
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            #2;
            if (mif.hilo_we_o) strobes++;
            @(posedge clk); #1;
        end
    endtask
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold, input string tag);
        logic [64:0] exp;
        int stalls, at;
        logic [31:0] ghi, glo;
        logic gdbz;
        exp = model(op, a, b);
        mif.alucontrol_i = op;
        mif.a_i = a;
        mif.b_i = b;
        mif.valid_i = 1'b1;
        mif.flush_i = 1'b0;
        stalls = 0;
        at = -1;
        ghi = '0;
        glo = '0;
        gdbz = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #2;
            if (mif.stall_o) stalls++;
            if (mif.hilo_we_o) begin
                at = cyc;
                ghi = mif.hi_o;
                glo = mif.lo_o;
                gdbz = mif.dbz_o;
                break;
            end
            @(posedge clk); #1;
            if (!hold) begin
                mif.valid_i = 1'b0;
                mif.alucontrol_i = 8'($urandom);
                mif.a_i = $urandom;
                mif.b_i = $urandom;
            end
        end
        chk($sformatf("%s_lat", tag), 64'(at), 64'd33);
        chk($sformatf("%s_stalls", tag), 64'(stalls), 64'd33);
        chk($sformatf("%s_hi", tag), 64'(ghi), 64'(exp[63:32]));
        chk($sformatf("%s_lo", tag), 64'(glo), 64'(exp[31:0]));
        chk($sformatf("%s_dbz", tag), 64'(gdbz), 64'(exp[64]));
        last_hi = exp[63:32];
        last_lo = exp[31:0];
        @(posedge clk); #1;
    endtask
    initial begin
        logic [7:0] ops [4];
        logic [31:0] ra, rb;
        int s;
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
        rst = 1'b1;
        mif.valid_i = 1'b0;
        mif.flush_i = 1'b0;
        mif.alucontrol_i = '0;
        mif.a_i = '0;
        mif.b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        #2;
        chk("rst_stall", 64'(mif.stall_o), 64'd0);
        chk("rst_busy", 64'(mif.busy_o), 64'd0);
        chk("rst_we", 64'(mif.hilo_we_o), 64'd0);
        chk("rst_hi", 64'(mif.hi_o), 64'd0);
        chk("rst_lo", 64'(mif.lo_o), 64'd0);
        chk("rst_dbz", 64'(mif.dbz_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(OP_MULTU, 32'hffff_ffff, 32'hffff_ffff, 1'b0, "multu_max");
        do_op(OP_MULT, 32'hffff_ffff, 32'hffff_ffff, 1'b0, "mult_m1m1");
        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min");
        do_op(OP_MULT, 32'd7, 32'hffff_fffd, 1'b0, "mult_7m3");
        do_op(OP_DIV, 32'hffff_fff9, 32'd2, 1'b0, "div_m7_2");
        do_op(OP_DIV, 32'h8000_0000, 32'hffff_ffff, 1'b0, "div_ovf");
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "divu_100_7");
        do_op(OP_DIV, 32'h1234_5678, 32'd0, 1'b0, "div_dbz");
        do_op(OP_DIVU, 32'hdead_beef, 32'd0, 1'b0, "divu_dbz");
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            do_op(ops[$urandom_range(0, 3)], ra, rb, 1'b0, $sformatf("rand%0d", i));
        end
        mif.alucontrol_i = OP_DIV;
        mif.a_i = 32'd1000;
        mif.b_i = 32'd3;
        mif.valid_i = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            mif.valid_i = 1'b0;
        end
        mif.flush_i = 1'b1;
        #2;
        chk("flush5_busy_before", 64'(mif.busy_o), 64'd1);
        @(posedge clk); #1;
        mif.flush_i = 1'b0;
        #2;
        chk("flush5_busy", 64'(mif.busy_o), 64'd0);
        chk("flush5_stall", 64'(mif.stall_o), 64'd0);
        chk("flush5_hi_hold", 64'(mif.hi_o), 64'(last_hi));
        chk("flush5_lo_hold", 64'(mif.lo_o), 64'(last_lo));
        watch(40, s);
        chk("flush5_no_write", 64'(s), 64'd0);
        mif.alucontrol_i = OP_DIV;
        mif.valid_i = 1'b1;
        mif.flush_i = 1'b1;
        #2;
        chk("flush_start_stall", 64'(mif.stall_o), 64'd0);
        @(posedge clk); #1;
        mif.valid_i = 1'b0;
        mif.flush_i = 1'b0;
        #2;
        chk("flush_start_busy", 64'(mif.busy_o), 64'd0);
        @(posedge clk); #1;
        mif.alucontrol_i = 8'h20;
        mif.valid_i = 1'b1;
        #2;
        chk("other_op_stall", 64'(mif.stall_o), 64'd0);
        @(posedge clk); #1;
        mif.valid_i = 1'b0;
        #2;
        chk("other_op_busy", 64'(mif.busy_o), 64'd0);
        chk("other_op_lo_hold", 64'(mif.lo_o), 64'(last_lo));
        @(posedge clk); #1;
        do_op(OP_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b1, "b2b_first");
        do_op(OP_MULTU, 32'hcafe_f00d, 32'h1357_9bdf, 1'b0, "b2b_second");
        mif.alucontrol_i = OP_DIVU;
        mif.a_i = 32'h7654_3210;
        mif.b_i = 32'd13;
        mif.valid_i = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            mif.valid_i = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("rstmid_busy", 64'(mif.busy_o), 64'd0);
        chk("rstmid_stall", 64'(mif.stall_o), 64'd0);
        chk("rstmid_hi", 64'(mif.hi_o), 64'd0);
        chk("rstmid_lo", 64'(mif.lo_o), 64'd0);
        watch(40, s);
        chk("rstmid_no_write", 64'(s), 64'd0);
        do_op(OP_DIV, 32'hffff_ff9c, 32'd7, 1'b0, "after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
